// File: rtl/risc_v_reg_ctrl.sv
// Register-file port controller: post-reset clear of x1..x31, writeback pass-through and a
// bounded-wait debug access port. Optional clear sequence enabled by RF_CLEAR_ON_RESET_EN.
module risc_v_reg_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] id_r1_addr,
  input  logic [DATA_W-1:0] rf_r1_data,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_r1_addr,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              core_stall,
  output logic              init_done,
  output logic              wb_drop
);

  localparam int unsigned PendW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StInit, StRun, StDbg, StAck} state_e;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StRun;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [PendW-1:0]   pend_cnt_q, pend_cnt_d;
  logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
  logic               wb_drop_q, wb_drop_d;
  logic               starved;

  assign starved = (pend_cnt_q == PendW'(STARVE_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ResetState;
      clr_cnt_q   <= ADDR_W'(1);
      pend_cnt_q  <= '0;
      dbg_rdata_q <= '0;
      wb_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
      wb_drop_q   <= wb_drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    wb_drop_d   = wb_drop_q;
    case (state_q)
      StInit: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (&clr_cnt_q) state_d = StRun;
        if (wb_en) wb_drop_d = 1'b1;
      end
      StRun: begin
        if (dbg_req) begin
          if (wb_en) begin
            if (!starved) pend_cnt_d = pend_cnt_q + PendW'(1);
          end else begin
            state_d    = StDbg;
            pend_cnt_d = '0;
          end
        end else begin
          pend_cnt_d = '0;
        end
      end
      StDbg: begin
        // Writeback owns the write port this cycle; the debug access retries next cycle.
        if (!wb_en) begin
          if (!dbg_we) dbg_rdata_d = rf_r1_data;
          state_d = StAck;
        end
      end
      StAck:   state_d = StRun;
      default: state_d = ResetState;
    endcase
  end

  always_comb begin
    rf_w_en    = 1'b0;
    rf_w_addr  = wb_addr;
    rf_w_data  = wb_data;
    rf_r1_addr = id_r1_addr;
    core_stall = 1'b1;
    init_done  = 1'b1;
    dbg_ack    = 1'b0;
    case (state_q)
      StInit: begin
        rf_w_en   = 1'b1;
        rf_w_addr = clr_cnt_q;
        rf_w_data = '0;
        init_done = 1'b0;
      end
      StRun: begin
        rf_w_en    = wb_en;
        core_stall = starved;
      end
      StDbg: begin
        rf_r1_addr = dbg_addr;
        if (wb_en) begin
          rf_w_en = 1'b1;
        end else if (dbg_we) begin
          rf_w_en   = 1'b1;
          rf_w_addr = dbg_addr;
          rf_w_data = dbg_wdata;
        end
      end
      StAck: begin
        rf_w_en = wb_en;
        dbg_ack = 1'b1;
      end
      default: ;
    endcase
    if (rf_w_addr == '0) rf_w_en = 1'b0;
    // Hold the port quiet and the front end frozen while reset is asserted.
    if (!reset_n) begin
      rf_w_en    = 1'b0;
      core_stall = 1'b1;
      init_done  = 1'b0;
      dbg_ack    = 1'b0;
    end
  end

  assign dbg_rdata = dbg_rdata_q;
  assign wb_drop   = wb_drop_q;

endmodule

// File: tb/tb_risc_v_reg_ctrl.sv
// Scoreboard bench for risc_v_reg_ctrl: expected register-file writes and debug acks are queued
// by the stimulus and popped by a monitor whenever the DUT presents them.
module tb_risc_v_reg_ctrl;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  id_r1_addr;
  logic [31:0] rf_r1_data;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [4:0]  rf_r1_addr;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        core_stall;
  logic        init_done;
  logic        wb_drop;

  logic [31:0] rf_mem [32];
  wr_t         exp_wr [$];
  logic [31:0] exp_ack [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  risc_v_reg_ctrl #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .id_r1_addr(id_r1_addr),
    .rf_r1_data(rf_r1_data),
    .rf_w_en   (rf_w_en),
    .rf_w_addr (rf_w_addr),
    .rf_w_data (rf_w_data),
    .rf_r1_addr(rf_r1_addr),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .core_stall(core_stall),
    .init_done (init_done),
    .wb_drop   (wb_drop)
  );

  // Register-file model behind the controller.
  always @(posedge clk) if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
  assign rf_r1_data = (rf_r1_addr == 5'd0) ? 32'd0 : rf_mem[rf_r1_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT writes the register file or acks.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rf_w_en) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", 32'(rf_w_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(rf_w_addr), 32'(e.a));
          check("wr_data", rf_w_data, e.d);
        end
      end
      if (dbg_ack) begin
        if (exp_ack.size() == 0) begin
          check("unexpected_ack_rdata", dbg_rdata, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] r;
          r = exp_ack.pop_front();
          check("ack_rdata", dbg_rdata, r);
        end
      end
    end
  end

  task automatic dbg_op(input logic we, input logic [4:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string nm);
    tick();
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    if (we && a != 5'd0) exp_wr.push_back('{a: a, d: wd});
    exp_ack.push_back(exp_rd);
    @(negedge clk);
    check({nm, "_run_stall"}, 32'(core_stall), 32'd0);
    check({nm, "_run_r1addr"}, 32'(rf_r1_addr), 32'(id_r1_addr));
    check({nm, "_early_ack"}, 32'(dbg_ack), 32'd0);
    @(negedge clk);
    check({nm, "_dbg_stall"}, 32'(core_stall), 32'd1);
    check({nm, "_dbg_r1addr"}, 32'(rf_r1_addr), 32'(a));
    @(negedge clk);
    check({nm, "_ack"}, 32'(dbg_ack), 32'd1);
    check({nm, "_ack_stall"}, 32'(core_stall), 32'd1);
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    check({nm, "_post_stall"}, 32'(core_stall), 32'd0);
    check({nm, "_post_ack"}, 32'(dbg_ack), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; id_r1_addr = 5'd17;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_wb_drop", 32'(wb_drop), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd1);
    check("rst_w_en", 32'(rf_w_en), 32'd0);
`ifdef RF_CLEAR_ON_RESET_EN
    for (int i = 1; i < 32; i++) exp_wr.push_back('{a: 5'(i), d: 32'd0});
`endif
    tick();
    reset_n = 1'b1;
`ifdef RF_CLEAR_ON_RESET_EN
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      check("init_stall", 32'(core_stall), 32'd1);
      check("init_not_done", 32'(init_done), 32'd0);
      tick();
      wb_en = (i == 4); wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    check("run_init_done", 32'(init_done), 32'd1);
    check("run_stall", 32'(core_stall), 32'd0);
    check("run_wb_drop", 32'(wb_drop), 32'd1);
`else
    @(negedge clk);
    check("run_init_done", 32'(init_done), 32'd1);
    check("run_stall", 32'(core_stall), 32'd0);
    check("run_wb_drop", 32'(wb_drop), 32'd0);
`endif

    dbg_op(1'b1, 5'd5, 32'h1234_5678, 32'h0, "dw_x5");
    dbg_op(1'b0, 5'd5, 32'h0, 32'h1234_5678, "dr_x5");
    dbg_op(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678, "dw_x0");
    dbg_op(1'b0, 5'd0, 32'h0, 32'h0, "dr_x0");

    // Debug read of x9 starved by continuous writeback to x9.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hC0DE_0000;
    exp_wr.push_back('{a: 5'd9, d: 32'hC0DE_0000});
    exp_ack.push_back(32'hC0DE_0005);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("starve_stall", 32'(core_stall), (i >= 4) ? 32'd1 : 32'd0);
      tick();
      if (i < 5) begin
        wb_data = 32'hC0DE_0000 + 32'(i + 1);
        exp_wr.push_back('{a: 5'd9, d: wb_data});
      end else begin
        wb_en = 1'b0;
      end
    end
    @(negedge clk);
    check("starve_hold_stall", 32'(core_stall), 32'd1);
    check("starve_no_ack", 32'(dbg_ack), 32'd0);
    @(negedge clk);
    check("starve_dbg_stall", 32'(core_stall), 32'd1);
    @(negedge clk);
    check("starve_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    check("starve_pend_cleared", 32'(core_stall), 32'd0);

    // Writeback and debug write to x7 collide in DBG.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1;
    exp_ack.push_back(32'hC0DE_0005);
    tick();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
    exp_wr.push_back('{a: 5'd7, d: 32'hA5A5_A5A5});
    exp_wr.push_back('{a: 5'd7, d: 32'h1});
    @(negedge clk);
    check("coll_no_ack1", 32'(dbg_ack), 32'd0);
    check("coll_stall1", 32'(core_stall), 32'd1);
    tick();
    wb_en = 1'b0;
    @(negedge clk);
    check("coll_no_ack2", 32'(dbg_ack), 32'd0);
    @(negedge clk);
    check("coll_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    dbg_op(1'b0, 5'd7, 32'h0, 32'h1, "dr_x7");

    // Reset asserted while a debug read sits in DBG: no ack may follow.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    @(negedge clk);
    @(negedge clk);
    check("abort_dbg_stall", 32'(core_stall), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_ack", 32'(dbg_ack), 32'd0);
    check("abort_rdata", dbg_rdata, 32'd0);
    check("abort_w_en", 32'(rf_w_en), 32'd0);
    check("abort_stall", 32'(core_stall), 32'd1);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_wb_drop", 32'(wb_drop), 32'd0);
    dbg_req = 1'b0;
    repeat (2) @(posedge clk);
`ifdef RF_CLEAR_ON_RESET_EN
    for (int i = 1; i < 32; i++) exp_wr.push_back('{a: 5'(i), d: 32'd0});
`endif
    tick();
    reset_n = 1'b1;
`ifdef RF_CLEAR_ON_RESET_EN
    repeat (31) @(negedge clk);
`endif
    @(negedge clk);
    check("rerun_init_done", 32'(init_done), 32'd1);
    check("rerun_stall", 32'(core_stall), 32'd0);
    check("rerun_ack", 32'(dbg_ack), 32'd0);
    check("left_writes", 32'(exp_wr.size()), 32'd0);
    check("left_acks", 32'(exp_ack.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_v_reg_ctrl.md
Name: risc_v_reg_ctrl

Overview:
Write-port and read-port controller in front of the 32x32 register file. After reset it sequences a clear of x1..x31 through the single write port. It then passes pipeline writeback through and shares the register file with a debug requester, using a req/ack handshake and a bounded-wait stall. It sits between the WB stage, the ID stage read port 1 and the register-file instance.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register address width (registers 0..2^ADDR_W-1)
STARVE_MAX, 4, cycles a pending debug request may be blocked by writeback before core_stall is forced

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
wb_en  input  1  pipeline writeback valid
wb_addr  input  ADDR_W  writeback destination
wb_data  input  DATA_W  writeback data
id_r1_addr  input  ADDR_W  ID-stage read-port-1 address
rf_r1_data  input  DATA_W  register-file read-port-1 data (combinational)
rf_w_en  output  1  register-file write enable
rf_w_addr  output  ADDR_W  register-file write address
rf_w_data  output  DATA_W  register-file write data
rf_r1_addr  output  ADDR_W  register-file read-port-1 address (muxed)
dbg_req  input  1  debug access request, level, held until ack
dbg_we  input  1  1=write, 0=read; stable while dbg_req=1
dbg_addr  input  ADDR_W  debug register address; stable while dbg_req=1
dbg_wdata  input  DATA_W  debug write data; stable while dbg_req=1
dbg_ack  output  1  one-cycle completion pulse
dbg_rdata  output  DATA_W  read result, valid with dbg_ack, held until next ack
core_stall  output  1  freeze IF/ID; pipeline continues draining
init_done  output  1  clear sequence complete
wb_drop  output  1  sticky: writeback arrived during INIT and was discarded

Behaviour:
- Reset (reset_n=0, async):
  - State goes to INIT with clr_cnt=1; pend_cnt=0.
  - Outputs: dbg_ack=0, dbg_rdata=0, init_done=0, wb_drop=0, core_stall=1, rf_w_en=0.
  - Reset mid-operation aborts any debug transaction; no ack is issued.
- States: INIT, RUN, DBG, ACK.
- INIT:
  - rf_w_en=1, rf_w_addr=clr_cnt, rf_w_data=0; clr_cnt increments each cycle.
  - Exactly 31 write cycles (x1..x31). After clr_cnt=31 -> RUN; init_done=1 from the first RUN cycle onward.
  - x0 is never written.
  - core_stall=1 throughout.
  - wb_en=1 in INIT: the write is discarded and wb_drop is set (sticky until reset).
- Write port mux, outside INIT:
  - rf_w_en/addr/data follow wb_* when wb_en=1.
  - Otherwise they follow the debug write in DBG.
  - Otherwise rf_w_en=0.
  - rf_w_en is forced 0 whenever the selected address is 0.
- Read port mux: rf_r1_addr = dbg_addr in DBG, else id_r1_addr.
- RUN:
  - dbg_req=1 and wb_en=0 -> DBG, pend_cnt cleared.
  - dbg_req=1 and wb_en=1 -> pend_cnt increments, saturating at STARVE_MAX.
  - core_stall=1 when pend_cnt==STARVE_MAX, else 0.
- DBG:
  - core_stall=1.
  - If wb_en=1: writeback wins, debug is retried, and the state stays DBG.
  - Else the access is performed this cycle. Read: dbg_rdata <= rf_r1_data at the clock edge. Write: the register file is written.
  - Then -> ACK.
- ACK:
  - dbg_ack=1 for this single cycle; core_stall=1; dbg_req is ignored; -> RUN.
  - Requester must drop dbg_req in the cycle after ack or it is treated as a new request.
- Latency: an unblocked debug access goes dbg_req rise (in RUN) -> DBG next cycle -> dbg_ack the cycle after. Ack is 2 cycles after the request is sampled.
- A debug write to x0 completes with ack and has no effect. A debug read of x0 returns whatever the register file drives, which is 0.

Optional Feature:
RF_CLEAR_ON_RESET_EN
- Defined: INIT clear sequence as above.
- Undefined: reset enters RUN directly with init_done=1 and core_stall=0 after reset release; register contents stay as preloaded; wb_drop is permanently 0.

Test Plan:
- Reset release, macro defined -> 31 consecutive rf_w_en cycles with addr 1..31 and data 0; core_stall=1 throughout; init_done=1 on cycle 32; x0 never addressed.
- wb_en=1, wb_addr=3, wb_data=0xDEADBEEF asserted during INIT -> no write; wb_drop=1 and stays 1 through RUN until reset.
- In RUN with wb_en=0: debug write x5=0x12345678, then debug read x5 -> each ack 2 cycles after req; dbg_rdata=0x12345678; core_stall high only in DBG/ACK.
- dbg_req held while wb_en=1 continuously -> core_stall rises after 4 blocked cycles; once wb_en drops -> DBG, then ack; pend_cnt cleared.
- wb_en=1 (x7=0xA5A5A5A5) in the same cycle as DBG write x7=0x1 -> the WB write goes through first; the debug write follows next cycle; final x7=0x1; one ack.
- reset_n pulsed low during DBG -> no dbg_ack; outputs at reset values; INIT restarts from x1.
